// File: rtl/mlp_train_sequencer_pkg.sv
// Shared types and constants for the MLP training sequencer and its sample store.
package mlp_train_sequencer_pkg;

    localparam logic [15:0] ONE            = 16'h0100;
    localparam logic [15:0] THRESH_DEFAULT = 16'h0080;

    typedef enum logic [2:0] {
        StIdle,
        StTrain,
        StEvalSettle,
        StEvalCapture,
        StDone
    } state_t;

    typedef struct packed {
        logic [15:0] x1;
        logic [15:0] x2;
        logic [15:0] y;
    } sample_t;

    // Power-on contents: the XOR truth table; entries beyond it are zero.
    function automatic sample_t xor_sample(input int unsigned idx);
        sample_t s;
        case (idx)
            1:       s = '{x1: 16'h0000, x2: ONE,        y: ONE};
            2:       s = '{x1: ONE,      x2: 16'h0000,   y: ONE};
            3:       s = '{x1: ONE,      x2: ONE,        y: 16'h0000};
            default: s = '{x1: 16'h0000, x2: 16'h0000,   y: 16'h0000};
        endcase
        return s;
    endfunction

endpackage

// File: rtl/mlp_train_sequencer_sample_store.sv
// Training sample register file: one write port, one asynchronous read port.
module mlp_sample_store
    import mlp_train_sequencer_pkg::*;
#(
    parameter int unsigned NUM_SAMPLES = 4,
    parameter int unsigned AW          = $clog2(NUM_SAMPLES)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  sample_t       i_wdata,
    input  logic [AW-1:0] i_raddr,
    output sample_t       o_rdata
);

    sample_t r_mem [NUM_SAMPLES];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int unsigned i = 0; i < NUM_SAMPLES; i++) begin
                r_mem[i] <= xor_sample(i);
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/mlp_train_sequencer.sv
// Sequences MLP training over stored samples, then evaluates each sample and scores the result.
module mlp_train_sequencer
    import mlp_train_sequencer_pkg::*;
#(
    parameter int unsigned NUM_SAMPLES = 4,
    parameter int unsigned NUM_EPOCHS  = 250,
    parameter logic [15:0] THRESH      = THRESH_DEFAULT
) (
    input  logic                            i_clk,
    input  logic                            i_rst_n,
    input  logic                            i_start,
    input  logic                            i_load_en,
    input  logic [$clog2(NUM_SAMPLES)-1:0]  i_load_addr,
    input  logic [15:0]                     i_load_x1,
    input  logic [15:0]                     i_load_x2,
    input  logic [15:0]                     i_load_y,
    input  logic [15:0]                     i_mlp_y_out,
    input  logic                            i_mlp_training_done,
    output logic [15:0]                     o_x1,
    output logic [15:0]                     o_x2,
    output logic [15:0]                     o_y_target,
    output logic                            o_train,
    output logic                            o_busy,
    output logic                            o_eval_valid,
    output logic [$clog2(NUM_SAMPLES)-1:0]  o_eval_idx,
    output logic                            o_eval_pred,
    output logic [$clog2(NUM_SAMPLES):0]    o_correct_count,
    output logic                            o_all_correct,
    output logic                            o_done
);

    localparam int unsigned AW = $clog2(NUM_SAMPLES);
    localparam int unsigned EW = (NUM_EPOCHS > 1) ? $clog2(NUM_EPOCHS) : 1;
    localparam logic [AW-1:0] IDX_LAST   = AW'(NUM_SAMPLES - 1);
    localparam logic [EW-1:0] EPOCH_LAST = EW'(NUM_EPOCHS - 1);
    localparam logic [AW:0]   CNT_FULL   = (AW + 1)'(NUM_SAMPLES);

    state_t        r_state, w_state_next;
    logic [AW-1:0] r_idx, w_idx_next;
    logic [EW-1:0] r_epoch, w_epoch_next;
    logic [AW:0]   r_correct, w_correct_next;
    logic          r_eval_valid, w_eval_valid_next;
    logic [AW-1:0] r_eval_idx, w_eval_idx_next;
    logic          r_eval_pred, w_eval_pred_next;

    logic          w_idle_or_done;
    logic [AW-1:0] w_raddr;
    sample_t       w_rdata;
    sample_t       w_wdata;
    logic          w_pred;
    logic          w_target;

    assign w_idle_or_done = (r_state == StIdle) || (r_state == StDone);
    assign w_raddr        = w_idle_or_done ? '0 : r_idx;
    assign w_wdata        = '{x1: i_load_x1, x2: i_load_x2, y: i_load_y};

    mlp_sample_store #(
        .NUM_SAMPLES (NUM_SAMPLES),
        .AW          (AW)
    ) u_store (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_we    (i_load_en && w_idle_or_done),
        .i_waddr (i_load_addr),
        .i_wdata (w_wdata),
        .i_raddr (w_raddr),
        .o_rdata (w_rdata)
    );

    assign w_pred   = (i_mlp_y_out >= THRESH);
    assign w_target = (w_rdata.y >= THRESH);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= StIdle;
            r_idx        <= '0;
            r_epoch      <= '0;
            r_correct    <= '0;
            r_eval_valid <= 1'b0;
            r_eval_idx   <= '0;
            r_eval_pred  <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_idx        <= w_idx_next;
            r_epoch      <= w_epoch_next;
            r_correct    <= w_correct_next;
            r_eval_valid <= w_eval_valid_next;
            r_eval_idx   <= w_eval_idx_next;
            r_eval_pred  <= w_eval_pred_next;
        end
    end

    always_comb begin
        w_state_next      = r_state;
        w_idx_next        = r_idx;
        w_epoch_next      = r_epoch;
        w_correct_next    = r_correct;
        w_eval_valid_next = 1'b0;
        w_eval_idx_next   = r_eval_idx;
        w_eval_pred_next  = r_eval_pred;
        case (r_state)
            StIdle, StDone: begin
                if (i_start) begin
                    w_state_next   = StTrain;
                    w_idx_next     = '0;
                    w_epoch_next   = '0;
                    w_correct_next = '0;
                end
            end
            StTrain: begin
                // The final sample of the last epoch is still trained before leaving.
                if (i_mlp_training_done || (r_idx == IDX_LAST && r_epoch == EPOCH_LAST)) begin
                    w_state_next = StEvalSettle;
                    w_idx_next   = '0;
                end else begin
                    w_idx_next = r_idx + 1'b1;
                    if (r_idx == IDX_LAST) begin
                        w_epoch_next = r_epoch + 1'b1;
                    end
                end
            end
            StEvalSettle: begin
                w_state_next = StEvalCapture;
            end
            StEvalCapture: begin
                w_eval_valid_next = 1'b1;
                w_eval_idx_next   = r_idx;
                w_eval_pred_next  = w_pred;
                if (w_pred == w_target) begin
                    w_correct_next = r_correct + 1'b1;
                end
                if (r_idx == IDX_LAST) begin
                    w_state_next = StDone;
                end else begin
                    w_idx_next   = r_idx + 1'b1;
                    w_state_next = StEvalSettle;
                end
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    assign o_x1            = w_rdata.x1;
    assign o_x2            = w_rdata.x2;
    assign o_y_target      = w_rdata.y;
    assign o_train         = (r_state == StTrain);
    assign o_busy          = !w_idle_or_done;
    assign o_eval_valid    = r_eval_valid;
    assign o_eval_idx      = r_eval_idx;
    assign o_eval_pred     = r_eval_pred;
    assign o_correct_count = r_correct;
    assign o_done          = (r_state == StDone);
    assign o_all_correct   = (r_state == StDone) && (r_correct == CNT_FULL);

endmodule

// File: tb/tb_mlp_train_sequencer.sv
// Directed-plus-random bench for mlp_train_sequencer against a sample-array reference model.
module tb_mlp_train_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, load_en, mlp_training_done;
    logic [1:0]  load_addr;
    logic [15:0] load_x1, load_x2, load_y, mlp_y_out;
    logic [15:0] x1, x2, y_target;
    logic        train, busy, eval_valid, eval_pred, all_correct, done;
    logic [1:0]  eval_idx;
    logic [2:0]  correct_count;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] mx1 [4];
    logic [15:0] mx2 [4];
    logic [15:0] my  [4];

    always #5 clk = ~clk;

    mlp_train_sequencer dut (
        .i_clk               (clk),
        .i_rst_n             (rst_n),
        .i_start             (start),
        .i_load_en           (load_en),
        .i_load_addr         (load_addr),
        .i_load_x1           (load_x1),
        .i_load_x2           (load_x2),
        .i_load_y            (load_y),
        .i_mlp_y_out         (mlp_y_out),
        .i_mlp_training_done (mlp_training_done),
        .o_x1                (x1),
        .o_x2                (x2),
        .o_y_target          (y_target),
        .o_train             (train),
        .o_busy              (busy),
        .o_eval_valid        (eval_valid),
        .o_eval_idx          (eval_idx),
        .o_eval_pred         (eval_pred),
        .o_correct_count     (correct_count),
        .o_all_correct       (all_correct),
        .o_done              (done)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        mx1 = '{16'h0000, 16'h0000, 16'h0100, 16'h0100};
        mx2 = '{16'h0000, 16'h0100, 16'h0000, 16'h0100};
        my  = '{16'h0000, 16'h0100, 16'h0100, 16'h0000};
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ctl"}, {train, busy, eval_valid, done, all_correct}, 5'b0);
        chk({tag, "_cnt"}, 64'(correct_count), 64'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        chk_reset_outputs("async_reset");
        #2 rst_n = 1'b1;
        tick();
        chk("idle_sample0", {x1, x2, y_target}, {mx1[0], mx2[0], my[0]});
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Write through the load port; the model follows only when the store should accept it.
    task automatic write_sample(input logic [1:0] a, input logic [15:0] d1, d2, dy,
                                input bit accepted);
        load_en = 1'b1; load_addr = a; load_x1 = d1; load_x2 = d2; load_y = dy;
        if (accepted) begin
            mx1[a] = d1; mx2[a] = d2; my[a] = dy;
        end
    endtask

    // Training phase: expects sample[k mod 4] on cycle k and exit after abort_at (or 1000 cycles).
    task automatic run_train(input int abort_at, input int wr_at);
        int k = 0;
        int exp_cycles = (abort_at < 0) ? 1000 : abort_at + 1;
        pulse_start();
        while (train === 1'b1 && k < 1100) begin
            if (k % 97 == 0 || k < 8 || k >= exp_cycles - 4)
                chk("train_sample", {x1, x2, y_target}, {mx1[k % 4], mx2[k % 4], my[k % 4]});
            if (k == abort_at) mlp_training_done = 1'b1;
            if (k == wr_at) write_sample(2'd2, 16'h0200, 16'h0200, 16'h0100, 1'b0);
            if (k == 5) start = 1'b1;
            tick();
            mlp_training_done = 1'b0;
            load_en = 1'b0;
            start = 1'b0;
            k++;
        end
        chk("train_cycles", 64'(k), 64'(exp_cycles));
        chk("post_train", {train, busy, done}, 3'b010);
        chk("settle_sample0", {x1, x2, y_target}, {mx1[0], mx2[0], my[0]});
    endtask

    // Evaluation phase; starts in the first settle cycle.
    task automatic run_eval(input logic [3:0][15:0] yv);
        int cnt = 0;
        bit pred;
        for (int j = 0; j < 4; j++) begin
            chk("eval_settle_x", {x1, x2, y_target, train}, {mx1[j], mx2[j], my[j], 1'b0});
            mlp_y_out = yv[j];
            tick();
            chk("eval_capture", {busy, eval_valid, done}, 3'b100);
            tick();
            pred = (yv[j] >= 16'h0080);
            if (pred == (my[j] >= 16'h0080)) cnt++;
            chk("eval_pulse", {eval_valid, 2'(eval_idx), eval_pred}, {1'b1, 2'(j), pred});
            chk("eval_count", 64'(correct_count), 64'(cnt));
        end
        chk("done_flags", {done, busy, train, all_correct}, {3'b100, cnt == 4});
        tick();
        chk("done_pulse_end", {eval_valid, done}, 2'b01);
    endtask

    initial begin
        logic [3:0][15:0] ry;
        rst_n = 1'b0; start = 1'b0; load_en = 1'b0; mlp_training_done = 1'b0;
        load_addr = '0; load_x1 = '0; load_x2 = '0; load_y = '0; mlp_y_out = '0;
        #3;
        model_reset();
        chk_reset_outputs("power_on");
        #10 rst_n = 1'b1;
        tick();
        chk("idle_sample0", {x1, x2, y_target}, {mx1[0], mx2[0], my[0]});

        // Full 250 epochs with a write attempt during TRAIN that must be ignored.
        for (int i = 0; i < 4; i++) ry[i] = 16'($urandom_range(0, 16'hFFFF));
        run_train(-1, 10);
        run_eval(ry);

        run_train(37, -1);
        run_eval({16'h0030, 16'h00C0, 16'h0030, 16'h00C0});

        run_train(int'($urandom_range(0, 60)), -1);
        run_eval({16'h0030, 16'h00C0, 16'h00C0, 16'h0030});

        run_train(int'($urandom_range(0, 60)), -1);
        run_eval({16'h007F, 16'h0080, 16'h007F, 16'h0080});

        // Write in DONE is accepted and must appear on the next run.
        write_sample(2'd2, 16'h0200, 16'h0200, 16'h0100, 1'b1);
        tick();
        load_en = 1'b0;
        run_train(9, -1);
        for (int i = 0; i < 4; i++) ry[i] = 16'($urandom_range(0, 16'hFFFF));
        run_eval(ry);

        // Random accepted writes from DONE, then a random run.
        for (int i = 0; i < 3; i++) begin
            write_sample(2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom),
                         16'($urandom), 1'b1);
            tick();
        end
        load_en = 1'b0;
        run_train(int'($urandom_range(0, 40)), -1);
        for (int i = 0; i < 4; i++) ry[i] = 16'($urandom_range(0, 16'hFFFF));
        run_eval(ry);

        // Reset mid-TRAIN restores state and the XOR sample set.
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (6) tick();
        chk("mid_train", 64'(train), 64'd1);
        do_reset();
        run_train(14, -1);
        run_eval({16'h0000, 16'hFFFF, 16'h0100, 16'h0000});

        // Reset mid-EVAL_CAPTURE after one correct evaluation.
        run_train(3, -1);
        mlp_y_out = 16'h0000;
        tick();
        tick();
        chk("pre_reset_count", 64'(correct_count), 64'd1);
        mlp_y_out = 16'h00C0;
        tick();
        chk("in_capture", {busy, eval_valid}, 2'b10);
        do_reset();
        run_train(int'($urandom_range(0, 30)), -1);
        run_eval({16'h0000, 16'h0100, 16'h0100, 16'h0000});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
